pc_button_cmd: RTL and testbench

PC_BUTTON_CMD -- requirements
Module: pc_button_cmd

---
 rtl/pc_cmd_pkg.sv | 52 +++++
 rtl/btn_debounce.sv | 82 ++++++++
 rtl/pc_button_cmd.sv | 84 ++++++++
 tb/tb_pc_button_cmd.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_cmd_pkg.sv
// pc_cmd_pkg: command codes, widths and helpers shared between the button
// front-end (pc_button_cmd) and the program counter that consumes commands.
package pc_cmd_pkg;

  localparam int unsigned CMD_W   = 3;
  localparam int unsigned DATA_W  = 8;
  localparam int unsigned NUM_BTN = 5;

  // Button bit positions; lower index = higher priority.
  localparam int unsigned BTN_S = 0;
  localparam int unsigned BTN_U = 1;
  localparam int unsigned BTN_D = 2;
  localparam int unsigned BTN_R = 3;
  localparam int unsigned BTN_L = 4;

  typedef enum logic [CMD_W-1:0] {
    CMD_NONE   = 3'd0,
    CMD_STEP   = 3'd1,
    CMD_INC    = 3'd2,
    CMD_DEC    = 3'd3,
    CMD_BRANCH = 3'd4,
    CMD_LOAD   = 3'd5
  } cmd_code_e;

  typedef enum logic [1:0] {
    DB_IDLE,
    DB_PRESS_WAIT,
    DB_HELD,
    DB_REL_WAIT
  } db_state_e;

  typedef struct packed {
    cmd_code_e         code;
    logic [DATA_W-1:0] data;
  } cmd_payload_t;

  // Isolate the lowest set bit (highest-priority pending button).
  function automatic logic [NUM_BTN-1:0] pick_first(input logic [NUM_BTN-1:0] v);
    return v & (NUM_BTN'(~v) + NUM_BTN'(1));
  endfunction

  // Map a one-hot button vector to its command code.
  function automatic cmd_code_e onehot_to_code(input logic [NUM_BTN-1:0] oh);
    if (oh[BTN_S]) return CMD_STEP;
    if (oh[BTN_U]) return CMD_INC;
    if (oh[BTN_D]) return CMD_DEC;
    if (oh[BTN_R]) return CMD_BRANCH;
    if (oh[BTN_L]) return CMD_LOAD;
    return CMD_NONE;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: 2-flop synchronizer plus press/release debounce FSM for one
// raw push-button. Emits a one-cycle press pulse when a press is accepted.
//   clock, reset : clock and async active-high reset
//   btn          : raw asynchronous button
//   press        : registered one-cycle pulse on accepted press
module btn_debounce
  import pc_cmd_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_W           = 20
) (
  input  logic clock,
  input  logic reset,
  input  logic btn,
  output logic press
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_1;
  logic             sync_2;
  db_state_e        state;
  logic [CNT_W-1:0] cnt;

  // Metastability filter
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
    end else begin
      sync_1 <= btn;
      sync_2 <= sync_1;
    end
  end

  // Debounce FSM; counter only advances in the two wait states and leaves
  // them at CNT_LAST, so it can never wrap.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= DB_IDLE;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      press <= 1'b0;
      case (state)
        DB_IDLE: begin
          if (sync_2) begin
            state <= DB_PRESS_WAIT;
            cnt   <= '0;
          end
        end
        DB_PRESS_WAIT: begin
          if (!sync_2) begin
            state <= DB_IDLE;
          end else if (cnt == CNT_LAST) begin
            state <= DB_HELD;
            press <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DB_HELD: begin
          if (!sync_2) begin
            state <= DB_REL_WAIT;
            cnt   <= '0;
          end
        end
        DB_REL_WAIT: begin
          if (sync_2) begin
            state <= DB_HELD;
          end else if (cnt == CNT_LAST) begin
            state <= DB_IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= DB_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/pc_button_cmd.sv
// pc_button_cmd: turns five debounced push-buttons into a prioritized
// valid/ready command stream for the program counter.
//   clock, reset        : clock and async active-high reset
//   btns/btnu/btnd/btnr/btnl : raw buttons (STEP/INC/DEC/BRANCH/LOAD)
//   new_count           : switch operand captured on BRANCH/LOAD press
//   cmd_valid/code/data : command output, held until cmd_ready
//   cmd_ready           : downstream accepts the displayed command
//   cmd_drop            : sticky, a press hit an already-pending command
module pc_button_cmd
  import pc_cmd_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_W           = 20
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              btns,
  input  logic              btnu,
  input  logic              btnd,
  input  logic              btnr,
  input  logic              btnl,
  input  logic [DATA_W-1:0] new_count,
  output logic              cmd_valid,
  output logic [CMD_W-1:0]  cmd_code,
  output logic [DATA_W-1:0] cmd_data,
  input  logic              cmd_ready,
  output logic              cmd_drop
);

  logic [NUM_BTN-1:0] raw;
  logic [NUM_BTN-1:0] press;
  logic [NUM_BTN-1:0] pending;
  logic [NUM_BTN-1:0] shown;
  logic [NUM_BTN-1:0] clr;
  logic [DATA_W-1:0]  branch_data;
  logic [DATA_W-1:0]  load_data;
  cmd_payload_t       payload;

  assign raw = {btnl, btnr, btnd, btnu, btns};

  for (genvar i = 0; i < NUM_BTN; i++) begin : gen_db
    btn_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_db (
      .clock (clock),
      .reset (reset),
      .btn   (raw[i]),
      .press (press[i])
    );
  end

  assign shown     = pick_first(pending);
  assign cmd_valid = |pending;
  assign clr       = (cmd_valid && cmd_ready) ? shown : '0;

  // Pending set wins over the same-cycle handshake clear, so a press landing
  // on the bit being delivered is delivered again.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pending     <= '0;
      branch_data <= '0;
      load_data   <= '0;
      cmd_drop    <= 1'b0;
    end else begin
      pending <= (pending & ~clr) | press;
      if (|(press & pending & ~clr)) cmd_drop <= 1'b1;
      if (press[BTN_R]) branch_data <= new_count;
      if (press[BTN_L]) load_data   <= new_count;
    end
  end

  // Output payload for the highest-priority pending button
  always_comb begin
    payload.code = onehot_to_code(shown);
    payload.data = '0;
    if (shown[BTN_R])      payload.data = branch_data;
    else if (shown[BTN_L]) payload.data = load_data;
  end

  assign cmd_code = payload.code;
  assign cmd_data = payload.data;

endmodule

// File: tb/tb_pc_button_cmd.sv
// tb_pc_button_cmd: table-driven single-press vectors, hand-written
// multi-cycle sequences, then randomized stimulus against a run-length
// debounce model with a pending-set scoreboard.
module tb_pc_button_cmd;
  import pc_cmd_pkg::*;

  localparam int DB = 4;

  logic       clock = 1'b0;
  logic       reset;
  logic [4:0] raw;
  logic       btns, btnu, btnd, btnr, btnl;
  logic [7:0] new_count;
  logic       cmd_ready;
  logic       cmd_valid;
  logic [2:0] cmd_code;
  logic [7:0] cmd_data;
  logic       cmd_drop;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  assign {btnl, btnr, btnd, btnu, btns} = raw;

  always #5 clock = ~clock;

  pc_button_cmd #(
    .DEBOUNCE_CYCLES (DB),
    .CNT_W           (3)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .btns      (btns),
    .btnu      (btnu),
    .btnd      (btnd),
    .btnr      (btnr),
    .btnl      (btnl),
    .new_count (new_count),
    .cmd_valid (cmd_valid),
    .cmd_code  (cmd_code),
    .cmd_data  (cmd_data),
    .cmd_ready (cmd_ready),
    .cmd_drop  (cmd_drop)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    raw       = '0;
    cmd_ready = 1'b0;
    new_count = '0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  // Edges until cmd_valid is seen (-1 if not within max)
  task automatic wait_valid(input int max, output int edges);
    edges = -1;
    for (int k = 1; k <= max; k++) begin
      @(posedge clock);
      @(negedge clock);
      if (cmd_valid) begin
        edges = k;
        break;
      end
    end
  endtask

  task automatic run_count(input int n, output int cnt, output logic [2:0] code);
    cnt  = 0;
    code = '0;
    repeat (n) begin
      @(posedge clock);
      @(negedge clock);
      if (cmd_valid) begin
        cnt++;
        code = cmd_code;
      end
    end
  endtask

  // ---------------- reference model ----------------
  // A button flips its debounced state once the synchronized input has
  // disagreed with that state for DB+1 consecutive samples.
  bit         m_pend [5];
  bit         m_press[5];
  bit         m_s1   [5];
  bit         m_s2   [5];
  bit         m_st   [5];
  int         m_run  [5];
  logic [7:0] m_bd, m_ld;
  bit         m_drop;

  function automatic int m_shown();
    for (int i = 0; i < 5; i++) if (m_pend[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    for (int b = 0; b < 5; b++) begin
      m_pend[b] = 0; m_press[b] = 0; m_s1[b] = 0; m_s2[b] = 0; m_st[b] = 0; m_run[b] = 0;
    end
    m_bd = '0; m_ld = '0; m_drop = 0;
  endtask

  task automatic model_step();
    int sh;
    bit inb;
    sh = m_shown();
    if (sh >= 0 && cmd_ready) m_pend[sh] = 0;
    for (int b = 0; b < 5; b++) begin
      if (m_press[b]) begin
        if (m_pend[b]) m_drop = 1;
        m_pend[b] = 1;
        if (b == 3) m_bd = new_count;
        if (b == 4) m_ld = new_count;
      end
    end
    for (int b = 0; b < 5; b++) begin
      inb        = m_s2[b];
      m_s2[b]    = m_s1[b];
      m_s1[b]    = raw[b];
      m_press[b] = 0;
      if (inb != m_st[b]) m_run[b]++;
      else m_run[b] = 0;
      if (m_run[b] == DB + 1) begin
        m_st[b]    = inb;
        m_run[b]   = 0;
        m_press[b] = inb;
      end
    end
  endtask

  function automatic logic [12:0] model_out();
    int sh;
    logic [2:0] c;
    logic [7:0] d;
    sh = m_shown();
    c  = (sh >= 0) ? 3'(sh + 1) : 3'd0;
    d  = (sh == 3) ? m_bd : (sh == 4) ? m_ld : 8'd0;
    return {sh >= 0, c, d, m_drop};
  endfunction

  // ---------------- vector table ----------------
  typedef struct {
    int         btn;
    logic [7:0] nc;
    int         hold;
    logic [2:0] exp_code;
    logic [7:0] exp_data;
    int         exp_count;
    int         exp_first;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int         e, cnt, c2, first;
    logic [2:0] gc;
    logic [7:0] gd;
    bit         stable;

    vecs[0] = '{0, 8'h11, 20, CMD_STEP,   8'h00, 1, 8};
    vecs[1] = '{1, 8'h22, 20, CMD_INC,    8'h00, 1, 8};
    vecs[2] = '{2, 8'h33, 6,  CMD_DEC,    8'h00, 1, 8};
    vecs[3] = '{3, 8'hA5, 5,  CMD_BRANCH, 8'hA5, 1, 8};
    vecs[4] = '{4, 8'h3C, 12, CMD_LOAD,   8'h3C, 1, 8};
    vecs[5] = '{1, 8'h44, 4,  CMD_NONE,   8'h00, 0, 0};
    vecs[6] = '{3, 8'h55, 1,  CMD_NONE,   8'h00, 0, 0};

    // Reset state
    reset = 1'b1; raw = '0; cmd_ready = 1'b0; new_count = '0;
    @(negedge clock); @(negedge clock);
    check("reset valid", cmd_valid, 0);
    check("reset code",  cmd_code,  CMD_NONE);
    check("reset data",  cmd_data,  0);
    check("reset drop",  cmd_drop,  0);

    // Single presses of varying length, cmd_ready held high
    for (int r = 0; r < 7; r++) begin
      do_reset();
      cmd_ready = 1'b1;
      new_count = vecs[r].nc;
      raw[vecs[r].btn] = 1'b1;
      cnt = 0; first = 0; gc = '0; gd = '0;
      for (int k = 1; k <= 40; k++) begin
        @(posedge clock);
        @(negedge clock);
        if (cmd_valid) begin
          cnt++;
          if (first == 0) begin
            first = k; gc = cmd_code; gd = cmd_data;
          end
        end
        if (k == vecs[r].hold) raw[vecs[r].btn] = 1'b0;
      end
      check($sformatf("vec%0d valid cycles", r), cnt, vecs[r].exp_count);
      if (vecs[r].exp_count > 0) begin
        check($sformatf("vec%0d latency", r), first, vecs[r].exp_first);
        check($sformatf("vec%0d code", r), gc, vecs[r].exp_code);
        check($sformatf("vec%0d data", r), gd, vecs[r].exp_data);
      end
    end

    // Bounce only, then bounce followed by steady high
    do_reset();
    cmd_ready = 1'b1;
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      raw[2] = ((i / 2) % 2 == 0);
      @(posedge clock); @(negedge clock);
      if (cmd_valid) cnt++;
    end
    raw[2] = 1'b0;
    run_count(20, c2, gc);
    check("bounce no cmd", cnt + c2, 0);
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      raw[2] = ((i / 2) % 2 == 0);
      @(posedge clock); @(negedge clock);
      if (cmd_valid) cnt++;
    end
    raw[2] = 1'b1;
    run_count(20, c2, gc);
    check("bounce then hold count", cnt + c2, 1);
    check("bounce then hold code", gc, CMD_DEC);

    // Priority and backpressure
    do_reset();
    new_count = 8'd7;
    raw[0] = 1'b1; raw[3] = 1'b1;
    wait_valid(20, e);
    check("prio latency", e, 8);
    check("prio first code", cmd_code, CMD_STEP);
    stable = 1;
    repeat (10) begin
      @(posedge clock); @(negedge clock);
      if (!(cmd_valid && cmd_code == CMD_STEP && cmd_data == 8'd0)) stable = 0;
    end
    check("prio stall stable", stable, 1);
    cmd_ready = 1'b1;
    @(posedge clock); @(negedge clock);
    check("prio second valid", cmd_valid, 1);
    check("prio second code", cmd_code, CMD_BRANCH);
    check("prio second data", cmd_data, 8'd7);
    @(posedge clock); @(negedge clock);
    check("prio drained", cmd_valid, 0);
    raw = '0;

    // Drop: LOAD re-pressed while still pending
    do_reset();
    new_count = 8'd5;
    raw[4] = 1'b1;
    run_count(8, cnt, gc);
    raw[4] = 1'b0;
    run_count(12, cnt, gc);
    check("drop not yet", cmd_drop, 0);
    new_count = 8'd3;
    raw[4] = 1'b1;
    run_count(8, cnt, gc);
    check("drop set", cmd_drop, 1);
    check("drop valid", cmd_valid, 1);
    check("drop code", cmd_code, CMD_LOAD);
    check("drop data", cmd_data, 8'd3);
    cmd_ready = 1'b1;
    @(posedge clock); @(negedge clock);
    check("drop delivered", cmd_valid, 0);
    check("drop sticky", cmd_drop, 1);
    raw = '0; cmd_ready = 1'b0;

    // Reset while INC pending and btnr mid-debounce
    new_count = 8'h42;
    raw[1] = 1'b1;
    wait_valid(20, e);
    check("rst inc latency", e, 8);
    check("rst inc code", cmd_code, CMD_INC);
    raw[1] = 1'b0; raw[3] = 1'b1;
    run_count(4, cnt, gc);
    reset = 1'b1;
    #1;
    check("rst valid", cmd_valid, 0);
    check("rst code", cmd_code, CMD_NONE);
    check("rst data", cmd_data, 0);
    check("rst drop", cmd_drop, 0);
    @(negedge clock); @(negedge clock);
    reset = 1'b0;
    wait_valid(20, e);
    check("rst branch latency", e, 8);
    check("rst branch code", cmd_code, CMD_BRANCH);
    check("rst branch data", cmd_data, 8'h42);

    // Randomized stimulus against the reference model
    do_reset();
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      check($sformatf("random cycle %0d {valid,code,data,drop}", c),
            {cmd_valid, cmd_code, cmd_data, cmd_drop}, model_out());
      for (int b = 0; b < 5; b++)
        if ($urandom_range(0, 5) == 0) raw[b] = ~raw[b];
      cmd_ready = 1'($urandom_range(0, 1));
      new_count = 8'($urandom);
      @(posedge clock);
      model_step();
      @(negedge clock);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
